// File: rtl/tx_sched.sv
// tx_sched: round-robin scheduler feeding one multi-frame UART transmitter.
// Ports: clk_in, rst_n_in (async low); req_valid_in/req_data_in/req_ready_out
//   per requester; grant_out; tx_new_data_out/tx_data_out/tx_busy_in to the
//   transmitter; done_out/done_id_out completion pulse and requester index.
module tx_sched #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_SIZE = 16
) (
  input  logic                         clk_in,
  input  logic                         rst_n_in,
  input  logic [NUM_REQ-1:0]           req_valid_in,
  input  logic [NUM_REQ*DATA_SIZE-1:0] req_data_in,
  output logic [NUM_REQ-1:0]           req_ready_out,
  output logic [NUM_REQ-1:0]           grant_out,
  output logic                         tx_new_data_out,
  output logic [DATA_SIZE-1:0]         tx_data_out,
  input  logic                         tx_busy_in,
  output logic                         done_out,
  output logic [$clog2(NUM_REQ)-1:0]   done_id_out
);

  localparam int IW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE
  } state_t;

  state_t state, state_nxt;

  logic [IW-1:0]      last_grant;
  logic [IW-1:0]      gnt_idx;
  logic [IW-1:0]      win_idx;
  logic [NUM_REQ-1:0] win_oh;
  logic               win_found;
  logic [1:0]         retry_cnt;
  logic [1:0]         tmo_cnt;
  logic               accept;
  logic               tmo_hit;
  logic               give_up;
  logic               retry_go;

  // Round-robin search starting just after the last winner.
  always_comb begin
    int j;
    logic [IW-1:0] idx;
    j         = 0;
    idx       = '0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = int'(last_grant) + 1 + i;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      idx = IW'(j);
      if (!win_found && req_valid_in[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  always_comb begin
    win_oh          = '0;
    win_oh[win_idx] = 1'b1;
  end

  assign accept   = (state == IDLE) && !tx_busy_in
                    && win_found;
  // Fourth consecutive idle cycle after a start pulse.
  assign tmo_hit  = (state == WAIT_START) && !tx_busy_in
                    && (tmo_cnt == 2'd3);
  assign give_up  = tmo_hit && (retry_cnt == 2'd3);
  assign retry_go = tmo_hit && !give_up;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    req_ready_out   = '0;
    tx_new_data_out = 1'b0;
    done_out        = 1'b0;
    unique case (state)
      IDLE: begin
        // Ready is combinational, so mask it while reset is held.
        if (accept && rst_n_in) begin
          req_ready_out = win_oh;
          state_nxt     = ISSUE;
        end
      end
      ISSUE: begin
        tx_new_data_out = 1'b1;
        state_nxt       = WAIT_START;
      end
      WAIT_START: begin
        if (tx_busy_in) begin
          state_nxt = WAIT_DONE;
        end else if (give_up) begin
          done_out  = 1'b1;
          state_nxt = IDLE;
        end else if (retry_go) begin
          state_nxt = ISSUE;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy_in) begin
          done_out  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign done_id_out = gnt_idx;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      last_grant  <= IW'(NUM_REQ - 1);
      gnt_idx     <= '0;
      grant_out   <= '0;
      tx_data_out <= '0;
      retry_cnt   <= '0;
      tmo_cnt     <= '0;
    end else begin
      if (accept) begin
        last_grant  <= win_idx;
        gnt_idx     <= win_idx;
        grant_out   <= win_oh;
        tx_data_out <=
          req_data_in[win_idx*DATA_SIZE +: DATA_SIZE];
        retry_cnt   <= '0;
      end else if (done_out) begin
        grant_out <= '0;
      end
      if (state == ISSUE) begin
        tmo_cnt <= '0;
      end else if (state == WAIT_START && !tx_busy_in) begin
        tmo_cnt <= tmo_cnt + 2'd1;
      end
      if (retry_go) retry_cnt <= retry_cnt + 2'd1;
    end
  end

endmodule

// File: tb/tb_tx_sched.sv
// tb_tx_sched: directed bench for tx_sched with a busy-flag transmitter
// model; checks arbitration order, retries, reset abort and busy hold-off.
module tb_tx_sched;

  localparam int NR       = 4;
  localparam int DW       = 16;
  localparam int BUSY_LEN = 10;

  logic          clk_in = 1'b0;
  logic          rst_n  = 1'b1;
  logic [NR-1:0] req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0] req_ready_out;
  logic [NR-1:0] grant_out;
  logic          tx_new_data_out;
  logic [DW-1:0] tx_data_out;
  logic          tx_busy;
  logic          done_out;
  logic [1:0]    done_id_out;
  logic          hold_busy = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk_in = ~clk_in;

  tx_sched #(.NUM_REQ(NR), .DATA_SIZE(DW)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n),
    .req_valid_in    (req_valid),
    .req_data_in     (req_data),
    .req_ready_out   (req_ready_out),
    .grant_out       (grant_out),
    .tx_new_data_out (tx_new_data_out),
    .tx_data_out     (tx_data_out),
    .tx_busy_in      (tx_busy),
    .done_out        (done_out),
    .done_id_out     (done_id_out)
  );

  // Transmitter model: busy for BUSY_LEN cycles after an accepted start.
  logic mdl_busy   = 1'b0;
  int   mdl_cnt    = 0;
  int   pulse_cnt  = 0;
  int   ign_until  = 0;
  logic never_busy = 1'b0;

  assign tx_busy = mdl_busy | hold_busy;

  always @(posedge clk_in) begin
    if (tx_new_data_out) begin
      pulse_cnt <= pulse_cnt + 1;
      if (pulse_cnt >= ign_until && !never_busy) begin
        mdl_busy <= 1'b1;
        mdl_cnt  <= BUSY_LEN - 1;
      end
    end else if (mdl_busy) begin
      if (mdl_cnt == 0) mdl_busy <= 1'b0;
      else              mdl_cnt  <= mdl_cnt - 1;
    end
  end

  int acc_q[$];
  int acc_cyc_q[$];
  int nd_cyc_q[$];
  logic [DW-1:0] nd_data_q[$];
  int done_q[$];
  int done_cyc_q[$];
  int cyc = 0;
  int onehot_bad = 0;

  function automatic int idx_of(input logic [NR-1:0] v);
    for (int i = NR - 1; i >= 0; i--)
      if (v[i]) return i;
    return -1;
  endfunction

  always @(negedge clk_in) begin
    cyc = cyc + 1;
    if (|req_ready_out) begin
      acc_q.push_back(idx_of(req_ready_out));
      acc_cyc_q.push_back(cyc);
    end
    if (tx_new_data_out) begin
      nd_cyc_q.push_back(cyc);
      nd_data_q.push_back(tx_data_out);
    end
    if (done_out) begin
      done_q.push_back(int'(done_id_out));
      done_cyc_q.push_back(cyc);
    end
    if ($countones(req_ready_out) > 1 ||
        $countones(grant_out) > 1)
      onehot_bad = onehot_bad + 1;
  end

  // One cycle of requester behaviour: drop valid after its accept edge.
  task automatic step(input logic [NR-1:0] keep,
                      output logic [NR-1:0] seen);
    @(negedge clk_in);
    seen = req_ready_out;
    if (|seen) begin
      @(posedge clk_in);
      #1;
      req_valid = req_valid & ~(seen & ~keep);
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk_in);
    #1 rst_n = 1'b0;
    req_data = {16'h3D3D, 16'h2C2C, 16'h1B1B, 16'h0A0A};
    repeat (3) @(negedge clk_in);
    checks++;
    if (req_ready_out !== '0) begin
      errors++;
      $display("FAIL rst_ready got %b want 0000", req_ready_out);
    end
    checks++;
    if (grant_out !== '0) begin
      errors++;
      $display("FAIL rst_grant got %b want 0000", grant_out);
    end
    checks++;
    if (tx_new_data_out !== 1'b0 || done_out !== 1'b0) begin
      errors++;
      $display("FAIL rst_pulses got nd=%b done=%b want 0 0",
               tx_new_data_out, done_out);
    end
    checks++;
    if (tx_data_out !== '0 || done_id_out !== '0) begin
      errors++;
      $display("FAIL rst_data got %h/%0d want 0/0",
               tx_data_out, done_id_out);
    end
    #1 rst_n = 1'b1;
    repeat (4) @(negedge clk_in);
    checks++;
    if (grant_out !== '0 || nd_cyc_q.size() != 0) begin
      errors++;
      $display("FAIL idle_hold got grant=%b nd=%0d want 0 0",
               grant_out, nd_cyc_q.size());
    end
  endtask

  task automatic test_order;
    int a0, d0, n0;
    logic [NR-1:0] s;
    logic [DW-1:0] exp_d [4];
    exp_d = '{16'h0A0A, 16'h1B1B, 16'h2C2C, 16'h3D3D};
    a0 = acc_q.size();
    d0 = done_q.size();
    n0 = nd_data_q.size();
    @(posedge clk_in);
    #1 req_valid = 4'b1111;
    for (int n = 0; n < 400 && done_q.size() < d0 + 4; n++)
      step('0, s);
    checks++;
    if (done_q.size() != d0 + 4) begin
      errors++;
      $display("FAIL order_timeout got %0d dones want 4",
               done_q.size() - d0);
      return;
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (acc_q[a0+k] != k) begin
        errors++;
        $display("FAIL order_acc%0d got %0d want %0d",
                 k, acc_q[a0+k], k);
      end
      checks++;
      if (done_q[d0+k] != k) begin
        errors++;
        $display("FAIL order_done%0d got %0d want %0d",
                 k, done_q[d0+k], k);
      end
      checks++;
      if (nd_data_q[n0+k] !== exp_d[k]) begin
        errors++;
        $display("FAIL order_data%0d got %h want %h",
                 k, nd_data_q[n0+k], exp_d[k]);
      end
    end
    checks++;
    if (acc_cyc_q[a0+1] - acc_cyc_q[a0] != 13) begin
      errors++;
      $display("FAIL accept_gap got %0d want 13",
               acc_cyc_q[a0+1] - acc_cyc_q[a0]);
    end
    checks++;
    if (done_cyc_q[d0] - acc_cyc_q[a0] != 12) begin
      errors++;
      $display("FAIL done_lat got %0d want 12",
               done_cyc_q[d0] - acc_cyc_q[a0]);
    end
  endtask

  task automatic test_round_robin;
    int a0, d0, cnt;
    logic [NR-1:0] s;
    int exp_id [3];
    exp_id = '{2, 0, 2};
    a0 = acc_q.size();
    d0 = done_q.size();
    cnt = 0;
    @(posedge clk_in);
    #1 req_valid = 4'b0100;
    for (int n = 0; n < 300 && cnt < 3; n++) begin
      step(4'b0100, s);
      if (|s) begin
        cnt++;
        if (cnt == 1) req_valid[0] = 1'b1;
      end
    end
    req_valid = '0;
    for (int n = 0; n < 300 && done_q.size() < d0 + 3; n++)
      @(negedge clk_in);
    checks++;
    if (cnt != 3 || done_q.size() != d0 + 3) begin
      errors++;
      $display("FAIL rr_timeout got acc=%0d done=%0d want 3 3",
               cnt, done_q.size() - d0);
      return;
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (acc_q[a0+k] != exp_id[k] ||
          done_q[d0+k] != exp_id[k]) begin
        errors++;
        $display("FAIL rr_%0d got acc=%0d done=%0d want %0d",
                 k, acc_q[a0+k], done_q[d0+k], exp_id[k]);
      end
    end
  endtask

  task automatic test_retry;
    int d0, n0;
    logic [NR-1:0] s;
    d0 = done_q.size();
    n0 = nd_cyc_q.size();
    @(posedge clk_in);
    #1;
    req_data[31:16] = 16'h5A5A;
    ign_until = pulse_cnt + 1;
    req_valid = 4'b0010;
    for (int n = 0; n < 200 && done_q.size() < d0 + 1; n++)
      step('0, s);
    checks++;
    if (done_q.size() != d0 + 1 ||
        nd_cyc_q.size() != n0 + 2) begin
      errors++;
      $display("FAIL retry_count got done=%0d nd=%0d want 1 2",
               done_q.size() - d0, nd_cyc_q.size() - n0);
      return;
    end
    checks++;
    if (nd_cyc_q[n0+1] - nd_cyc_q[n0] != 5) begin
      errors++;
      $display("FAIL retry_gap got %0d want 5",
               nd_cyc_q[n0+1] - nd_cyc_q[n0]);
    end
    checks++;
    if (nd_data_q[n0] !== 16'h5A5A ||
        nd_data_q[n0+1] !== 16'h5A5A) begin
      errors++;
      $display("FAIL retry_data got %h/%h want 5a5a",
               nd_data_q[n0], nd_data_q[n0+1]);
    end
    checks++;
    if (done_q[d0] != 1) begin
      errors++;
      $display("FAIL retry_id got %0d want 1", done_q[d0]);
    end
  endtask

  task automatic test_never_busy;
    int d0, n0;
    logic [NR-1:0] s;
    d0 = done_q.size();
    n0 = nd_cyc_q.size();
    @(posedge clk_in);
    #1;
    never_busy = 1'b1;
    req_valid = 4'b1000;
    for (int n = 0; n < 300 && done_q.size() < d0 + 1; n++)
      step('0, s);
    repeat (10) @(negedge clk_in);
    checks++;
    if (done_q.size() != d0 + 1 ||
        nd_cyc_q.size() != n0 + 4) begin
      errors++;
      $display("FAIL never_count got done=%0d nd=%0d want 1 4",
               done_q.size() - d0, nd_cyc_q.size() - n0);
      never_busy = 1'b0;
      return;
    end
    checks++;
    if (nd_cyc_q[n0+3] - nd_cyc_q[n0] != 15) begin
      errors++;
      $display("FAIL never_span got %0d want 15",
               nd_cyc_q[n0+3] - nd_cyc_q[n0]);
    end
    checks++;
    if (done_cyc_q[d0] - nd_cyc_q[n0] != 19) begin
      errors++;
      $display("FAIL never_done_at got %0d want 19",
               done_cyc_q[d0] - nd_cyc_q[n0]);
    end
    checks++;
    if (done_q[d0] != 3 || grant_out !== '0) begin
      errors++;
      $display("FAIL never_end got id=%0d grant=%b want 3 0000",
               done_q[d0], grant_out);
    end
    never_busy = 1'b0;
  endtask

  task automatic test_reset_mid;
    int a0, d0, cnt;
    logic [NR-1:0] s;
    cnt = 0;
    @(posedge clk_in);
    #1 req_valid = 4'b0001;
    for (int n = 0; n < 100 && cnt < 1; n++) begin
      step('0, s);
      if (|s) cnt++;
    end
    repeat (3) @(negedge clk_in);
    checks++;
    if (grant_out !== 4'b0001 || tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst got grant=%b busy=%b want 0001 1",
               grant_out, tx_busy);
    end
    a0 = acc_q.size();
    d0 = done_q.size();
    req_valid = 4'b0011;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (grant_out !== '0 || tx_data_out !== '0) begin
      errors++;
      $display("FAIL async_rst got grant=%b data=%h want 0 0",
               grant_out, tx_data_out);
    end
    checks++;
    if (req_ready_out !== '0 || tx_new_data_out !== 1'b0 ||
        done_out !== 1'b0 || done_id_out !== '0) begin
      errors++;
      $display("FAIL async_rst_ctl got r=%b n=%b d=%b i=%0d want 0",
               req_ready_out, tx_new_data_out, done_out,
               done_id_out);
    end
    @(negedge clk_in);
    #1 rst_n = 1'b1;
    cnt = 0;
    for (int n = 0; n < 300 && cnt < 2; n++) begin
      step('0, s);
      if (|s) cnt++;
    end
    for (int n = 0; n < 300 && done_q.size() < d0 + 2; n++)
      @(negedge clk_in);
    checks++;
    if (cnt != 2 || done_q.size() != d0 + 2) begin
      errors++;
      $display("FAIL mid_timeout got acc=%0d done=%0d want 2 2",
               cnt, done_q.size() - d0);
      return;
    end
    checks++;
    if (acc_q[a0] != 0 || acc_q[a0+1] != 1) begin
      errors++;
      $display("FAIL mid_order got %0d,%0d want 0,1",
               acc_q[a0], acc_q[a0+1]);
    end
    checks++;
    if (done_q[d0] != 0 || done_q[d0+1] != 1) begin
      errors++;
      $display("FAIL mid_done got %0d,%0d want 0,1",
               done_q[d0], done_q[d0+1]);
    end
  endtask

  task automatic test_busy_hold;
    int d0;
    d0 = done_q.size();
    @(posedge clk_in);
    #1;
    hold_busy = 1'b1;
    req_valid = 4'b0010;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk_in);
      checks++;
      if (req_ready_out !== '0 || grant_out !== '0) begin
        errors++;
        $display("FAIL hold_%0d got r=%b g=%b want 0000 0000",
                 k, req_ready_out, grant_out);
      end
    end
    @(posedge clk_in);
    #1 hold_busy = 1'b0;
    @(negedge clk_in);
    checks++;
    if (req_ready_out !== 4'b0010) begin
      errors++;
      $display("FAIL hold_release got %b want 0010",
               req_ready_out);
    end
    @(posedge clk_in);
    #1 req_valid = '0;
    for (int n = 0; n < 100 && done_q.size() < d0 + 1; n++)
      @(negedge clk_in);
    checks++;
    if (done_q.size() != d0 + 1 || tx_data_out !== 16'h5A5A) begin
      errors++;
      $display("FAIL hold_done got n=%0d data=%h want 1 5a5a",
               done_q.size() - d0, tx_data_out);
    end
    else begin
      checks++;
      if (done_q[d0] != 1) begin
        errors++;
        $display("FAIL hold_id got %0d want 1", done_q[d0]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_order;
    test_round_robin;
    test_retry;
    test_never_busy;
    test_reset_mid;
    test_busy_hold;
    checks++;
    if (onehot_bad != 0) begin
      errors++;
      $display("FAIL onehot got %0d bad cycles want 0",
               onehot_bad);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/tx_sched.md
TX_SCHED -- requirements
Module: tx_sched

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of requesters sharing one multi-frame UART transmitter (legal range 2..16).
REQ-002 Parameter DATA_SIZE, default 16, SHALL set the message width in bits and match the transmitter's message width.
REQ-003 clk_in  input  1  SHALL be the single clock; all logic is rising-edge.
REQ-004 rst_n_in  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 req_valid_in  input  NUM_REQ  SHALL carry one per-requester "message pending" flag.
REQ-006 req_data_in  input  NUM_REQ*DATA_SIZE  SHALL carry the requester messages; requester k occupies bits [k*DATA_SIZE +: DATA_SIZE].
REQ-007 req_ready_out  output  NUM_REQ  SHALL be a one-hot, one-cycle accept pulse to the requester whose message is captured.
REQ-008 grant_out  output  NUM_REQ  SHALL be one-hot while a granted message is being issued or sent, and zero otherwise.
REQ-009 tx_new_data_out  output  1  SHALL be the start pulse to the transmitter.
REQ-010 tx_data_out  output  DATA_SIZE  SHALL carry the message presented to the transmitter.
REQ-011 tx_busy_in  input  1  SHALL be the transmitter busy flag.
REQ-012 done_out  output  1  SHALL pulse for one cycle when a granted message completes.
REQ-013 done_id_out  output  $clog2(NUM_REQ)  SHALL give the requester index that done_out refers to.

Function
REQ-014 The block SHALL use states IDLE, ISSUE, WAIT_START and WAIT_DONE.
REQ-015 In IDLE, when tx_busy_in=0 and any req_valid_in bit is 1, the block SHALL select a winner and move to ISSUE on the next edge.
- In the same cycle it SHALL pulse req_ready_out[winner].
- It SHALL register req_data_in slice [winner] into tx_data_out.
- It SHALL set grant_out to the winner and update last_grant to the winner.
REQ-016 Arbitration SHALL be round-robin: the search starts at index (last_grant+1) mod NUM_REQ, and the first set valid bit wins.
REQ-017 In IDLE with tx_busy_in=1, the block SHALL make no selection and emit no ready pulse.
REQ-018 In ISSUE, tx_new_data_out SHALL be 1 for exactly that one cycle, after which the block SHALL move to WAIT_START.
REQ-019 In WAIT_START, tx_busy_in=1 SHALL move the block to WAIT_DONE.
- If tx_busy_in stays 0 for 4 consecutive cycles (dropped start), the block SHALL return to ISSUE and re-pulse tx_new_data_out with the same tx_data_out.
- At most 3 retries SHALL be made; after that the block SHALL go to IDLE with done_out pulsed and grant_out cleared.
REQ-020 In WAIT_DONE, on the first cycle with tx_busy_in=0 the block SHALL:
- pulse done_out with done_id_out set to the granted index;
- clear grant_out;
- return to IDLE.
REQ-021 tx_data_out SHALL hold its value from capture until the next capture.
REQ-022 Requester data SHALL be sampled only in the accept cycle; a requester keeps valid and data stable until its ready pulse, and a deasserted valid is never granted.
REQ-023 The minimum gap between accepts SHALL be IDLE→ISSUE→WAIT_START→WAIT_DONE→IDLE, so back-to-back accepts are at least 4 cycles plus the transmit time apart.
REQ-024 A valid arriving in the same cycle that done_out pulses SHALL be considered in the following IDLE cycle.
REQ-025 At most one bit of req_ready_out and of grant_out SHALL be set at any time.

Reset
REQ-026 Asserting rst_n_in=0 SHALL immediately, without a clock, force all of the following, including mid-transfer:
- state=IDLE;
- last_grant=NUM_REQ-1, so that requester 0 wins first;
- retry counter and timeout counter to 0;
- req_ready_out, grant_out, tx_new_data_out, done_out and done_id_out to 0;
- tx_data_out to 0.
REQ-027 After rst_n_in deasserts, the block SHALL stay in IDLE until valid is asserted and tx_busy_in=0; no done_out pulse SHALL occur for a transfer aborted by reset.

Verification
REQ-028 Reset, then req_valid_in=4'b1111 with data 0x0A0A, 0x1B1B, 0x2C2C, 0x3D3D and a transmitter model busy 10 cycles -> accepts in order 0,1,2,3; four done_out pulses with done_id_out 0,1,2,3.
REQ-029 Requester 2 valid continuously, plus requester 0 after 2's first accept -> grant order 2,0,2: round-robin, with no starvation of requester 0.
REQ-030 Model ignores the first tx_new_data_out (busy stays 0) -> a second tx_new_data_out pulse 5 cycles later with an unchanged tx_data_out, then normal completion.
REQ-031 Model never asserts busy -> exactly 4 tx_new_data_out pulses, then done_out and a return to IDLE.
REQ-032 rst_n_in pulled low asynchronously during WAIT_DONE -> all outputs read 0 before the next clock edge; no done_out pulse after release; the next accept goes to requester 0.
REQ-033 tx_busy_in=1 held while requester 1 is valid -> no req_ready_out; accept occurs the cycle after busy falls.
